// File: rtl/nvram_sd_sync.sv
// nvram_sd_sync: backup-RAM save/load sequencer between the NVRAM
// buffer and the user_io SD sector interface.
module nvram_sd_sync #(
    parameter int SECT_BITS = 6,
    parameter int SLOT_BITS = 2,
    parameter int LBA_W     = 32,
    parameter int TIMEOUT_W = 24
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 downloading,
    input  logic                 img_mounted,
    input  logic [31:0]          img_size,
    input  logic                 bk_load,
    input  logic                 bk_save,
    input  logic [SLOT_BITS-1:0] slot,
    input  logic                 nvram_we,
    input  logic                 sd_ack,
    output logic [LBA_W-1:0]     sd_lba,
    output logic                 sd_rd,
    output logic                 sd_wr,
    output logic                 bk_ena,
    output logic                 busy,
    output logic                 loading,
    output logic                 dirty,
    output logic                 done,
    output logic                 error
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        XFER
    } state_t;

    state_t                 state, state_nxt;
    logic [SECT_BITS-1:0]   sector, sector_nxt, sector_inc;
    logic [SLOT_BITS-1:0]   slot_q, slot_nxt;
    logic [TIMEOUT_W-1:0]   cnt, cnt_nxt, cnt_inc;
    logic                   rd_nxt, wr_nxt, loading_nxt, busy_nxt;
    logic                   done_nxt, error_nxt, dirty_nxt;
    logic                   dirty_sv, dirty_sv_nxt;

    logic dl_q;
    logic ld_lvl, sv_lvl;
    logic ld_q, sv_q;
    logic ld_arm, sv_arm;
    logic ld_edge, sv_edge;
    logic ack_q, ack_rise, ack_fall;

    assign ld_lvl     = bk_load & bk_ena;
    assign sv_lvl     = bk_save & bk_ena;
    assign ack_rise   = sd_ack & ~ack_q;
    assign ack_fall   = ~sd_ack & ack_q;
    assign cnt_inc    = cnt + 1'b1;
    assign sector_inc = sector + 1'b1;
    assign sd_lba     = LBA_W'({slot_q, sector});

    // Save-file availability follows download start and image mounts.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            dl_q   <= 1'b0;
            bk_ena <= 1'b0;
        end else begin
            dl_q <= downloading;
            if (downloading & ~dl_q)
                bk_ena <= 1'b0;
            if (downloading & img_mounted & (img_size != 32'd0))
                bk_ena <= 1'b1;
            if (img_mounted & (img_size == 32'd0))
                bk_ena <= 1'b0;
        end
    end

    // Registered request edges; a request held high across reset
    // must be released once before it can act again.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ld_q    <= 1'b0;
            sv_q    <= 1'b0;
            ld_arm  <= 1'b0;
            sv_arm  <= 1'b0;
            ld_edge <= 1'b0;
            sv_edge <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            ld_arm  <= ld_arm | ~bk_load;
            sv_arm  <= sv_arm | ~bk_save;
            ld_q    <= ld_lvl;
            sv_q    <= sv_lvl;
            ld_edge <= ld_lvl & ~ld_q & ld_arm;
            sv_edge <= sv_lvl & ~sv_q & sv_arm;
            ack_q   <= sd_ack;
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            sector   <= '0;
            slot_q   <= '0;
            cnt      <= '0;
            sd_rd    <= 1'b0;
            sd_wr    <= 1'b0;
            loading  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            dirty    <= 1'b0;
            dirty_sv <= 1'b0;
        end else begin
            state    <= state_nxt;
            sector   <= sector_nxt;
            slot_q   <= slot_nxt;
            cnt      <= cnt_nxt;
            sd_rd    <= rd_nxt;
            sd_wr    <= wr_nxt;
            loading  <= loading_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            error    <= error_nxt;
            dirty    <= dirty_nxt;
            dirty_sv <= dirty_sv_nxt;
        end
    end

    // Next-state: request, ack wait with timeout, sector advance.
    always_comb begin
        state_nxt    = state;
        sector_nxt   = sector;
        slot_nxt     = slot_q;
        cnt_nxt      = cnt;
        rd_nxt       = sd_rd;
        wr_nxt       = sd_wr;
        loading_nxt  = loading;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        error_nxt    = 1'b0;
        dirty_nxt    = dirty | nvram_we;
        dirty_sv_nxt = dirty_sv | (busy & nvram_we);
        unique case (state)
            IDLE: begin
                if (ld_edge | sv_edge) begin
                    state_nxt    = REQ;
                    slot_nxt     = slot;
                    sector_nxt   = '0;
                    cnt_nxt      = '0;
                    loading_nxt  = ld_edge;
                    busy_nxt     = 1'b1;
                    rd_nxt       = ld_edge;
                    wr_nxt       = ~ld_edge;
                    dirty_sv_nxt = 1'b0;
                end
            end
            REQ: begin
                if (ack_rise) begin
                    rd_nxt    = 1'b0;
                    wr_nxt    = 1'b0;
                    state_nxt = XFER;
                end else if (&cnt_inc) begin
                    rd_nxt      = 1'b0;
                    wr_nxt      = 1'b0;
                    error_nxt   = 1'b1;
                    busy_nxt    = 1'b0;
                    loading_nxt = 1'b0;
                    state_nxt   = IDLE;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            XFER: begin
                if (ack_fall) begin
                    if (&sector) begin
                        done_nxt    = 1'b1;
                        busy_nxt    = 1'b0;
                        loading_nxt = 1'b0;
                        state_nxt   = IDLE;
                        dirty_nxt   = nvram_we | (~loading & dirty_sv);
                    end else begin
                        sector_nxt = sector_inc;
                        rd_nxt     = loading;
                        wr_nxt     = ~loading;
                        cnt_nxt    = '0;
                        state_nxt  = REQ;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_nvram_sd_sync.sv
// tb_nvram_sd_sync: randomized save/load transfers against a
// transaction-level model of the sector sequence and dirty flag.
module tb_nvram_sd_sync;

    localparam int SECT_BITS = 2;
    localparam int SLOT_BITS = 2;
    localparam int LBA_W     = 32;
    localparam int TIMEOUT_W = 4;
    localparam int NSECT     = 1 << SECT_BITS;

    logic                 clk_sys = 1'b0;
    logic                 reset;
    logic                 downloading, img_mounted;
    logic [31:0]          img_size;
    logic                 bk_load, bk_save;
    logic [SLOT_BITS-1:0] slot;
    logic                 nvram_we, sd_ack;
    logic [LBA_W-1:0]     sd_lba;
    logic                 sd_rd, sd_wr, bk_ena, busy, loading;
    logic                 dirty, done, error;

    int n_chk = 0;
    int n_err = 0;
    int n_done = 0;
    int n_errp = 0;
    bit resp_on = 1'b1;
    int dly_min = 1, dly_max = 5, hi_min = 1, hi_max = 5;
    logic [LBA_W:0] reqs[$];
    logic p_rd = 1'b0, p_wr = 1'b0;
    bit m_dirty;

    nvram_sd_sync #(
        .SECT_BITS(SECT_BITS),
        .SLOT_BITS(SLOT_BITS),
        .LBA_W    (LBA_W),
        .TIMEOUT_W(TIMEOUT_W)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .downloading(downloading),
        .img_mounted(img_mounted),
        .img_size   (img_size),
        .bk_load    (bk_load),
        .bk_save    (bk_save),
        .slot       (slot),
        .nvram_we   (nvram_we),
        .sd_ack     (sd_ack),
        .sd_lba     (sd_lba),
        .sd_rd      (sd_rd),
        .sd_wr      (sd_wr),
        .bk_ena     (bk_ena),
        .busy       (busy),
        .loading    (loading),
        .dirty      (dirty),
        .done       (done),
        .error      (error)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // SD side: ack each request after a delay, hold it a while.
    initial begin
        sd_ack = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (resp_on && (sd_rd || sd_wr) && !sd_ack) begin
                int d, h;
                d = $urandom_range(dly_max, dly_min);
                h = $urandom_range(hi_max, hi_min);
                repeat (d - 1) @(negedge clk_sys);
                sd_ack = 1'b1;
                repeat (h) @(negedge clk_sys);
                sd_ack = 1'b0;
            end
        end
    end

    // Monitor: log each new sector request and status pulses.
    initial begin
        forever begin
            @(negedge clk_sys);
            if (!reset) begin
                if ((sd_rd && !p_rd) || (sd_wr && !p_wr)) begin
                    reqs.push_back({sd_wr, sd_lba});
                    chk("rd_wr_excl", 64'(sd_rd & sd_wr), 64'd0);
                    chk("loading", 64'(loading), 64'(sd_rd));
                end
                if (done) begin
                    n_done++;
                    chk("busy_at_done", 64'(busy), 64'd0);
                end
                if (error) n_errp++;
            end
            p_rd = sd_rd;
            p_wr = sd_wr;
        end
    end

    task automatic mount(input logic [31:0] sz);
        @(negedge clk_sys); downloading = 1'b1;
        @(negedge clk_sys); img_mounted = 1'b1; img_size = sz;
        @(negedge clk_sys); img_mounted = 1'b0; downloading = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic pulse_we();
        @(negedge clk_sys); nvram_we = 1'b1;
        @(negedge clk_sys); nvram_we = 1'b0;
        m_dirty = 1'b1;
        @(negedge clk_sys);
        chk("dirty_set", 64'(dirty), 64'd1);
    endtask

    task automatic do_xfer(input bit ld, input bit sv, input int sl,
                           input bit we_mid, input bit poke);
        int d0, e0;
        logic [LBA_W:0] exp, got;
        reqs.delete();
        d0 = n_done;
        e0 = n_errp;
        @(negedge clk_sys);
        slot    = SLOT_BITS'(sl);
        bk_load = ld;
        bk_save = sv;
        fork
            begin
                for (int i = 0; i < 600; i++) begin
                    @(negedge clk_sys);
                    if (n_done != d0 || n_errp != e0) break;
                end
            end
            begin
                if (we_mid || poke) begin
                    for (int i = 0; i < 300 && reqs.size() < 2; i++)
                        @(negedge clk_sys);
                    @(negedge clk_sys);
                    if (we_mid) nvram_we = 1'b1;
                    if (poke) bk_save = 1'b0;
                    @(negedge clk_sys);
                    nvram_we = 1'b0;
                    if (poke) bk_save = 1'b1;
                end
            end
        join
        repeat (12) @(negedge clk_sys);
        bk_load = 1'b0;
        bk_save = 1'b0;
        chk("done_cnt", 64'(n_done - d0), 64'd1);
        chk("err_cnt", 64'(n_errp - e0), 64'd0);
        chk("n_req", 64'(reqs.size()), 64'(NSECT));
        for (int i = 0; i < NSECT; i++) begin
            exp = {~ld, LBA_W'(sl * NSECT + i)};
            got = (i < reqs.size()) ? reqs[i] : '1;
            chk("req_lba", 64'(got), 64'(exp));
        end
        m_dirty = ld ? 1'b0 : we_mid;
        chk("dirty_after", 64'(dirty), 64'(m_dirty));
        chk("idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        int hi;
        bit seen, errseen;
        int d0, nr;
        reset = 1'b1;
        downloading = 1'b0; img_mounted = 1'b0; img_size = '0;
        bk_load = 1'b0; bk_save = 1'b0; slot = '0; nvram_we = 1'b0;
        m_dirty = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("rst_outs", 64'({sd_rd, sd_wr, bk_ena, busy, loading,
                             dirty, done, error}), 64'd0);
        chk("rst_lba", 64'(sd_lba), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk_sys);

        // Load request without a save file does nothing.
        bk_load = 1'b1;
        repeat (10) @(negedge clk_sys);
        chk("gate_noreq", 64'(reqs.size()), 64'd0);
        bk_load = 1'b0;
        mount(32'd0);
        chk("ena_zero", 64'(bk_ena), 64'd0);
        mount(32'd2048);
        chk("ena_set", 64'(bk_ena), 64'd1);

        pulse_we();
        dly_min = 3; dly_max = 3; hi_min = 5; hi_max = 5;
        do_xfer(1'b0, 1'b1, 2, 1'b0, 1'b0);
        dly_min = 1; dly_max = 5; hi_min = 1; hi_max = 5;
        do_xfer(1'b0, 1'b1, 1, 1'b1, 1'b0);
        do_xfer(1'b1, 1'b1, 1, 1'b0, 1'b1);

        // No ack: request times out and raises error.
        pulse_we();
        resp_on = 1'b0;
        d0 = n_done;
        hi = 0; seen = 1'b0; errseen = 1'b0;
        @(negedge clk_sys);
        slot = 2'd0;
        bk_load = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_sys);
            if (sd_rd) begin
                hi++;
                seen = 1'b1;
            end else if (seen) begin
                chk("to_error", 64'(error), 64'd1);
                errseen = 1'b1;
                break;
            end
        end
        chk("to_seen", 64'(errseen), 64'd1);
        chk("to_len", 64'(hi), 64'd15);
        repeat (3) @(negedge clk_sys);
        chk("to_nodone", 64'(n_done - d0), 64'd0);
        chk("to_busy", 64'(busy), 64'd0);
        chk("to_dirty", 64'(dirty), 64'(m_dirty));
        bk_load = 1'b0;
        resp_on = 1'b1;
        do_xfer(1'b1, 1'b0, 3, 1'b0, 1'b0);

        for (int k = 0; k < 8; k++) begin
            int typ;
            bit we;
            typ = $urandom_range(2, 0);
            we  = (typ == 1) && ($urandom_range(1, 0) == 1);
            if ($urandom_range(1, 0) == 1) pulse_we();
            do_xfer(typ != 1, typ != 0, $urandom_range(3, 0), we,
                    $urandom_range(1, 0) == 1);
        end

        // Async reset in the transfer of sector 2.
        reqs.delete();
        @(negedge clk_sys);
        slot = 2'd1;
        bk_save = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_sys);
            if (reqs.size() == 3 && sd_ack && !sd_wr) break;
        end
        chk("rst_at_sect2", 64'(reqs.size()), 64'd3);
        #2 reset = 1'b1;
        #1;
        chk("arst_outs", 64'({sd_rd, sd_wr, bk_ena, busy, loading,
                              dirty, done, error}), 64'd0);
        chk("arst_lba", 64'(sd_lba), 64'd0);
        repeat (8) @(negedge clk_sys);
        reset = 1'b0;
        m_dirty = 1'b0;
        mount(32'd4096);
        chk("ena_again", 64'(bk_ena), 64'd1);
        nr = reqs.size();
        repeat (20) @(negedge clk_sys);
        chk("held_noreq", 64'(reqs.size() - nr), 64'd0);
        bk_save = 1'b0;
        repeat (2) @(negedge clk_sys);
        do_xfer(1'b0, 1'b1, 1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/nvram_sd_sync.md
Name: nvram_sd_sync

Overview:
- Parametrised backup-RAM save/load sequencer between the on-chip NVRAM dual-port buffer and the user_io SD sector interface.
- Successor to the fixed 64-sector, 4-slot save logic.
- Generalised in sector count, slot count and LBA width.
- Adds per-sector ack timeout, dirty tracking and explicit done/error status.
- Sits in the core top level beside user_io. The NVRAM port B address is {sd_lba[SECT_BITS-1:0], sd_buff_addr}.

Parameters:
SECT_BITS  6   log2 of 512-byte sectors per save slot
SLOT_BITS  2   log2 of number of save slots
LBA_W      32  width of sd_lba
TIMEOUT_W  24  ack-wait timeout counter width; timeout after 2^TIMEOUT_W-1 cycles

Ports:
clk_sys      in   1          system clock
reset        in   1          asynchronous, active-high reset
downloading  in   1          ROM download in progress (ioctl_download)
img_mounted  in   1          pulse: save image mounted
img_size     in   32         size of mounted image in bytes
bk_load      in   1          load request (level; rising edge acts)
bk_save      in   1          save request (level; rising edge acts)
slot         in   SLOT_BITS  save slot select, sampled at request
nvram_we     in   1          core write to NVRAM (marks dirty)
sd_ack       in   1          user_io sector acknowledge
sd_lba       out  LBA_W      sector address
sd_rd        out  1          sector read request
sd_wr        out  1          sector write request
bk_ena       out  1          save file available
busy         out  1          transfer in progress
loading      out  1          current transfer is a load
dirty        out  1          NVRAM modified since last load/save
done         out  1          1-cycle pulse: transfer completed
error        out  1          1-cycle pulse: transfer aborted on timeout

Behaviour:
- Reset (async, any time, including mid-transfer):
  - All outputs are 0, state is IDLE, sd_lba is 0.
  - Edge-detect history is cleared to 0. A request level still high after reset does not trigger.
- bk_ena:
  - Cleared on the rising edge of downloading.
  - Set on cycles where downloading && img_mounted && img_size != 0.
  - Cleared on img_mounted with img_size == 0.
- Request detect: registered edge detect on (bk_load & bk_ena) and (bk_save & bk_ena).
  - Acts only in IDLE. Edges arriving while busy are discarded, not queued.
  - If both rising edges occur in the same cycle, load wins.
- States:
  - IDLE: on a request go to REQ. Latch slot. Set sector=0 and sd_lba = {slot, sector} zero-extended to LBA_W. Set loading = load. Set busy=1. Assert sd_rd=load or sd_wr=~load. Clear the timeout counter.
  - REQ: the timeout counter increments each cycle.
    - On sd_ack rising: drop sd_rd/sd_wr, go to XFER.
    - If the counter reaches all-ones first: drop sd_rd/sd_wr, pulse error, clear busy/loading, go to IDLE. dirty is unchanged.
  - XFER: wait for sd_ack falling. XFER has no timeout.
    - If sector == 2^SECT_BITS-1: pulse done, clear busy/loading, go to IDLE.
    - Otherwise: sector+1, update sd_lba, re-assert the same request, clear the counter, go to REQ.
- sd_rd and sd_wr are never both 1. Each is held continuously from assert until ack rises.
- dirty:
  - Set on any cycle with nvram_we.
  - Cleared on the done cycle of a save or a load.
  - If nvram_we coincides with the save done cycle, set wins.
  - If nvram_we occurs during a save, dirty stays set after completion. The flag is tracked as set during the save and reapplied at done.
- sd_lba upper bits above SLOT_BITS+SECT_BITS are 0.
- Latency:
  - Request edge to sd_rd/sd_wr asserted: 2 cycles (1 for edge register, 1 for state register).
  - Final ack fall to done: 1 cycle.

Test Plan:
- Enable and save (SECT_BITS=2, SLOT_BITS=2): downloading 1->0 with img_mounted pulse and img_size=2048; then slot=2, bk_save rise; bench acks each request after 3 cycles, 5 cycles high.
  - Required: sd_wr for lba 8,9,10,11 in order; sd_rd stays 0; one done pulse; busy falls with done.
- Request gating: bk_load rise with bk_ena=0 -> no sd_rd. Mount with img_size=0 -> bk_ena stays 0.
- Precedence and busy: bk_load and bk_save rise in the same cycle -> load of 4 sectors. A second bk_save edge mid-transfer -> ignored; exactly 4 sectors total.
- Timeout (TIMEOUT_W=4): never ack -> sd_rd drops and error pulses 15 cycles after the request; done never pulses.
  - A following bk_load edge restarts at sector 0.
- Dirty:
  - nvram_we pulse -> dirty=1.
  - A save with no writes during it -> dirty=0 at done.
  - nvram_we during the save's second sector -> dirty=1 after done.
- Async reset in XFER of sector 2: outputs are 0 immediately, without waiting for a clock edge. After release with bk_save still high -> no new transfer until bk_save falls and rises again.
